// File: rtl/imem_pipe.sv
// Instruction memory between fetch and decode: a synchronous-read stage register feeding
// a small response FIFO, with fault tagging for misaligned/out-of-range PCs and a flush.
module imem_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 65536,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RESP_DEPTH = 3,
  parameter string       INIT_FILE  = "../init/imem_initialization.hex"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_instr,
  output logic [31:0]      resp_addr,
  output logic [1:0]       resp_fault
);

  localparam int unsigned B          = WIDTH / 8;
  localparam int unsigned LSB        = $clog2(B);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned PTR_W      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(RESP_DEPTH + 1);
  localparam logic [32:0] SPAN       = 33'(DEPTH) * 33'(B);
  localparam logic [31:0] ALIGN_MASK = 32'(B - 1);

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Misalignment is tested first so it wins over the range check.
  function automatic logic [1:0] classify(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    if ((addr & ALIGN_MASK) != '0) return FAULT_MISALIGN;
    if ((addr < BASE_ADDR) || (off >= SPAN)) return FAULT_RANGE;
    return FAULT_OK;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (32'(p) == RESP_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept, push, pop;
  logic [1:0]       req_fault;
  logic [IDX_W-1:0] req_idx;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_instr_q;
  logic [31:0]      s1_addr_q;
  logic [1:0]       s1_fault_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] fifo_instr_q [RESP_DEPTH];
  logic [31:0]      fifo_addr_q  [RESP_DEPTH];
  logic [1:0]       fifo_fault_q [RESP_DEPTH];

  always_comb begin
    req_fault  = classify(req_addr);
    req_idx    = IDX_W'((req_addr - BASE_ADDR) >> LSB);
    // Occupancy counts the stage register too, so every accepted fetch has a FIFO slot.
    req_ready  = !rst && !flush && ((32'(count_q) + 32'(s1_valid_q)) < RESP_DEPTH);
    accept     = req_valid && req_ready;
    resp_valid = (count_q != '0);
    pop        = resp_valid && resp_ready && !flush;
    push       = s1_valid_q && !flush;

    s1_valid_d = accept;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    resp_instr = resp_valid ? fifo_instr_q[rd_ptr_q] : '0;
    resp_addr  = resp_valid ? fifo_addr_q[rd_ptr_q]  : '0;
    resp_fault = resp_valid ? fifo_fault_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Stage 1: synchronous memory read captured at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      if (req_fault == FAULT_OK) s1_instr_q <= mem[req_idx];
      else                       s1_instr_q <= '0;
      s1_addr_q  <= req_addr;
      s1_fault_q <= req_fault;
    end
  end

  // Stage 2: response FIFO storage, head drives resp_*
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= s1_instr_q;
      fifo_addr_q[wr_ptr_q]  <= s1_addr_q;
      fifo_fault_q[wr_ptr_q] <= s1_fault_q;
    end
  end

endmodule

// File: tb/tb_imem_pipe.sv
// Directed bench for imem_pipe: a queue-based behavioural model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_imem_pipe;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 65536;
  localparam int          RD    = 3;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk, rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_addr, resp_addr, resp_instr;
  logic [1:0]  resp_fault;

  imem_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RESP_DEPTH(RD), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_fault(resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
    int          e;
  } item_t;

  item_t mq[$];
  int    ecount = 0;
  int    cyc = 0;

  logic [31:0] log_instr[$];
  logic [31:0] log_addr[$];
  logic [1:0]  log_fault[$];
  int          log_cyc[$];

  function automatic item_t expect_for(input logic [31:0] a, input int e);
    item_t it;
    it.addr = a;
    it.e    = e;
    if (a % 4 != 0) begin
      it.fault = 2'b01; it.instr = 32'h0;
    end else if (a < BASE || (64'(a) - 64'(BASE)) >= 64'(DEPTH) * 4) begin
      it.fault = 2'b10; it.instr = 32'h0;
    end else begin
      it.fault = 2'b00; it.instr = 32'h1000_0000 + (a - BASE) / 4;
    end
    return it;
  endfunction

  always @(posedge clk) cyc++;

  // Model: every accepted fetch is queued with its accept edge; it becomes visible
  // one edge later and leaves on a consumer handshake, a flush or reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      bit vpre, rpre;
      vpre = 1'b0;
      if (mq.size() > 0) vpre = (ecount >= mq[0].e + 1);
      rpre = !flush && (mq.size() < RD);
      ecount++;
      if (flush) begin
        mq.delete();
      end else begin
        if (vpre && resp_ready) void'(mq.pop_front());
        if (req_valid && rpre) mq.push_back(expect_for(req_addr, ecount));
      end
    end
  end

  always @(negedge clk) begin
    bit er, ev;
    er = !rst && !flush && (mq.size() < RD);
    ev = 1'b0;
    if (!rst && mq.size() > 0) ev = (ecount >= mq[0].e + 1);
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, ev);
    if (ev) begin
      chk("resp_instr", resp_instr, mq[0].instr);
      chk("resp_addr", resp_addr, mq[0].addr);
      chk("resp_fault", resp_fault, mq[0].fault);
    end
    if (rst) begin
      chk("rst_instr", resp_instr, 0);
      chk("rst_addr", resp_addr, 0);
      chk("rst_fault", resp_fault, 0);
    end
    if (resp_valid && resp_ready && !flush && !rst) begin
      log_instr.push_back(resp_instr);
      log_addr.push_back(resp_addr);
      log_fault.push_back(resp_fault);
      log_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int base, acc;
    logic [31:0] a;
    logic [31:0] fa[3];
    logic [1:0]  ff[3];

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = 32'h1000_0000 + i;
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_instr", resp_instr, 0);
    step(); step();
    rst = 1'b0;

    // Single fetch, 2-cycle latency
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h8;
    step();
    req_valid = 1'b0;
    step();
    chk("single_valid", resp_valid, 1);
    chk("single_instr", resp_instr, 32'h1000_0002);
    chk("single_addr", resp_addr, 32'h8);
    chk("single_fault", resp_fault, 2'b00);
    step(); step();

    // Back-to-back, no bubbles
    base = log_instr.size();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 32'(4 * i);
      chk("b2b_ready", req_ready, 1);
      step();
    end
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("b2b_count", log_instr.size(), base + 4);
    if (log_instr.size() >= base + 4) begin
      chk("b2b_i0", log_instr[base],     32'h1000_0000);
      chk("b2b_i1", log_instr[base + 1], 32'h1000_0001);
      chk("b2b_i2", log_instr[base + 2], 32'h1000_0002);
      chk("b2b_i3", log_instr[base + 3], 32'h1000_0003);
      for (int k = 1; k < 4; k++) chk("b2b_gap", log_cyc[base + k] - log_cyc[base + k - 1], 1);
    end

    // Backpressure: exactly three accepts, then in-order drain
    resp_ready = 1'b0;
    base = log_instr.size();
    acc = 0; a = 32'h0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_addr = a;
      if (req_ready) begin acc++; a = a + 4; end
      step();
    end
    chk("bp_accepts", acc, 3);
    chk("bp_ready_low", req_ready, 0);
    req_valid = 1'b0; resp_ready = 1'b1;
    step(); step(); step(); step(); step();
    chk("bp_count", log_instr.size(), base + 3);
    if (log_instr.size() >= base + 3) begin
      chk("bp_i0", log_instr[base],     32'h1000_0000);
      chk("bp_i1", log_instr[base + 1], 32'h1000_0001);
      chk("bp_i2", log_instr[base + 2], 32'h1000_0002);
    end

    // Faults
    fa[0] = 32'h6; fa[1] = 32'h0004_0000; fa[2] = 32'h0004_0002;
    ff[0] = 2'b01; ff[1] = 2'b10;         ff[2] = 2'b01;
    base = log_instr.size();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = fa[i];
      step();
    end
    req_valid = 1'b0;
    step(); step(); step(); step();
    chk("fault_count", log_instr.size(), base + 3);
    if (log_instr.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("fault_code", log_fault[base + i], ff[i]);
        chk("fault_instr", log_instr[base + i], 0);
        chk("fault_addr", log_addr[base + i], fa[i]);
      end
    end

    // Flush discards in-flight fetches and blocks the concurrent request
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'(4 * i);
      step();
    end
    flush = 1'b1; req_addr = 32'h40;
    chk("flush_ready", req_ready, 0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_valid", resp_valid, 0);
    base = log_instr.size();
    resp_ready = 1'b1;
    step(); step(); step();
    chk("flush_no_stale", log_instr.size(), base);
    req_valid = 1'b1; req_addr = 32'h40;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("flush_refetch_count", log_instr.size(), base + 1);
    if (log_instr.size() >= base + 1) chk("flush_refetch", log_instr[base], 32'h1000_0010);

    // Asynchronous reset with fetches in flight
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", req_ready, 0);
    chk("arst_valid", resp_valid, 0);
    chk("arst_instr", resp_instr, 0);
    step(); step();
    rst = 1'b0;
    base = log_instr.size();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h20;
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("arst_count", log_instr.size(), base + 1);
    if (log_instr.size() >= base + 1) begin
      chk("arst_first_instr", log_instr[base], 32'h1000_0008);
      chk("arst_first_addr", log_addr[base], 32'h20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
